// File: rtl/uart_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : uart_pkg
// Purpose : Shared register offsets, bit positions and FSM encodings for the
//           UART controller.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
package uart_pkg;

   // Register selects, decoded from addr[4:2]
   localparam logic [2:0] OFF_STATUS = 3'd0;
   localparam logic [2:0] OFF_CTRL   = 3'd1;
   localparam logic [2:0] OFF_TXDATA = 3'd2;
   localparam logic [2:0] OFF_RXDATA = 3'd3;
   localparam logic [2:0] OFF_ERRCLR = 3'd4;

   // STATUS bit positions
   localparam int ST_TX_COUNT_LSB = 0;
   localparam int ST_RX_COUNT_LSB = 9;
   localparam int ST_TX_FULL      = 18;
   localparam int ST_RX_EMPTY     = 19;
   localparam int ST_TX_BUSY      = 20;
   localparam int ST_OVERRUN      = 21;
   localparam int ST_FRAMING      = 22;
   localparam int ST_PARITY       = 23;

   // CTRL bit positions
   localparam int CT_PARITY_EN  = 16;
   localparam int CT_PARITY_ODD = 17;
   localparam int CT_TWO_STOP   = 18;
   localparam int CT_IRQ_RX_EN  = 19;
   localparam int CT_IRQ_TXE_EN = 20;

   localparam logic [15:0] DIV_MIN = 16'd4;

   typedef enum logic [2:0] {
      TX_IDLE   = 3'd0,
      TX_START  = 3'd1,
      TX_DATA   = 3'd2,
      TX_PARITY = 3'd3,
      TX_STOP   = 3'd4
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_IDLE   = 3'd0,
      RX_START  = 3'd1,
      RX_DATA   = 3'd2,
      RX_PARITY = 3'd3,
      RX_STOP   = 3'd4
   } rx_state_t;

   // Divisors below the minimum cannot place a mid-bit sample, so clamp them
   function automatic logic [15:0] clamp_div(input logic [15:0] d);
      return (d < DIV_MIN) ? DIV_MIN : d;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : sync_fifo
// Purpose : Single-clock FIFO with occupancy count; pushes when full and pops
//           when empty are ignored.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign full     = (count == DEPTH_CNT);
   assign empty    = (count == '0);
   assign pop_data = mem[rd_ptr];

   // Storage array carries no reset; only valid entries are ever read
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // Pointers wrap naturally at the power-of-two depth
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : uart_ctrl
// Purpose : Register-mapped UART with TX/RX FIFOs, parity, 1/2 stop bits,
//           sticky error flags and a level interrupt.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
module uart_ctrl
   import uart_pkg::*;
#(
   parameter int CLK_DIV_RST = 16,
   parameter int FIFO_DEPTH  = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        tx,
   input  logic        rx,
   input  logic [5:0]  addr,
   input  logic [31:0] data_in,
   output logic [31:0] data_out,
   input  logic        write_enable,
   input  logic        read_enable,
   output logic        irq
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [2:0]    reg_sel;
   logic [15:0]   divisor;
   logic          parity_en, parity_odd, two_stop, irq_rx_en, irq_txe_en;
   logic          tx_push, tx_pop, tx_full, tx_empty, tx_busy;
   logic          rx_push, rx_pop, rx_full, rx_empty;
   logic [7:0]    tx_fifo_data, rx_fifo_data, rx_push_data;
   logic [CW-1:0] tx_count, rx_count;
   logic [8:0]    tx_count9, rx_count9;
   logic          errclr;
   logic          overrun, framing_err, parity_err;
   logic          unused_ok;

   assign reg_sel   = addr[4:2];
   assign tx_push   = write_enable && (reg_sel == OFF_TXDATA);
   assign rx_pop    = read_enable && (reg_sel == OFF_RXDATA) && !rx_empty;
   assign errclr    = write_enable && (reg_sel == OFF_ERRCLR);
   assign tx_count9 = 9'(tx_count);
   assign rx_count9 = 9'(rx_count);
   assign unused_ok = ^{addr[5], addr[1:0], data_in[31:24]};

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk(clk), .rst_n(rst_n), .push(tx_push), .push_data(data_in[7:0]),
      .pop(tx_pop), .pop_data(tx_fifo_data), .full(tx_full), .empty(tx_empty),
      .count(tx_count));

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk(clk), .rst_n(rst_n), .push(rx_push), .push_data(rx_push_data),
      .pop(rx_pop), .pop_data(rx_fifo_data), .full(rx_full), .empty(rx_empty),
      .count(rx_count));

   // CTRL register; divisor writes are clamped to the legal minimum
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         divisor    <= 16'(CLK_DIV_RST);
         parity_en  <= 1'b0;
         parity_odd <= 1'b0;
         two_stop   <= 1'b0;
         irq_rx_en  <= 1'b0;
         irq_txe_en <= 1'b0;
      end else if (write_enable && (reg_sel == OFF_CTRL)) begin
         divisor    <= clamp_div(data_in[15:0]);
         parity_en  <= data_in[CT_PARITY_EN];
         parity_odd <= data_in[CT_PARITY_ODD];
         two_stop   <= data_in[CT_TWO_STOP];
         irq_rx_en  <= data_in[CT_IRQ_RX_EN];
         irq_txe_en <= data_in[CT_IRQ_TXE_EN];
      end
   end

   // ---------------- transmitter ----------------
   tx_state_t   tx_state;
   logic [15:0] tx_div, tx_cnt;
   logic [7:0]  tx_shift;
   logic [2:0]  tx_bit;
   logic        tx_par_en, tx_two_stop, tx_par_bit, tx_stop2;
   logic        tx_bit_end, tx_frame_done;

   assign tx_bit_end    = (tx_cnt == tx_div - 16'd1);
   assign tx_frame_done = (tx_state == TX_STOP) && tx_bit_end && (!tx_two_stop || tx_stop2);
   // A new frame starts from IDLE or straight out of the last stop bit
   assign tx_pop        = !tx_empty && ((tx_state == TX_IDLE) || tx_frame_done);
   assign tx_busy       = (tx_state != TX_IDLE);

   // TX frame sequencer; frame settings are latched when the byte is popped
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state    <= TX_IDLE;
         tx          <= 1'b1;
         tx_div      <= 16'(CLK_DIV_RST);
         tx_cnt      <= '0;
         tx_shift    <= '0;
         tx_bit      <= '0;
         tx_par_en   <= 1'b0;
         tx_two_stop <= 1'b0;
         tx_par_bit  <= 1'b0;
         tx_stop2    <= 1'b0;
      end else if (tx_pop) begin
         tx_state    <= TX_START;
         tx          <= 1'b0;
         tx_cnt      <= '0;
         tx_div      <= divisor;
         tx_par_en   <= parity_en;
         tx_two_stop <= two_stop;
         tx_par_bit  <= (^tx_fifo_data) ^ parity_odd;
         tx_shift    <= tx_fifo_data;
         tx_bit      <= '0;
         tx_stop2    <= 1'b0;
      end else if (tx_state != TX_IDLE) begin
         if (!tx_bit_end) begin
            tx_cnt <= tx_cnt + 16'd1;
         end else begin
            tx_cnt <= '0;
            case (tx_state)
               TX_START: begin
                  tx_state <= TX_DATA;
                  tx       <= tx_shift[0];
                  tx_shift <= tx_shift >> 1;
               end
               TX_DATA: begin
                  if (tx_bit == 3'd7) begin
                     tx_state <= tx_par_en ? TX_PARITY : TX_STOP;
                     tx       <= tx_par_en ? tx_par_bit : 1'b1;
                  end else begin
                     tx_bit   <= tx_bit + 3'd1;
                     tx       <= tx_shift[0];
                     tx_shift <= tx_shift >> 1;
                  end
               end
               TX_PARITY: begin
                  tx_state <= TX_STOP;
                  tx       <= 1'b1;
               end
               TX_STOP: begin
                  if (tx_two_stop && !tx_stop2) tx_stop2 <= 1'b1;
                  else                          tx_state <= TX_IDLE;
               end
               default: tx_state <= TX_IDLE;
            endcase
         end
      end
   end

   // ---------------- receiver ----------------
   logic        sync0, sync1, rx_prev, rx_fall;
   rx_state_t   rx_state;
   logic [15:0] rx_div, rx_cnt;
   logic [7:0]  rx_shift;
   logic [2:0]  rx_bit;
   logic        rx_par_en, rx_par_odd, rx_par_ok;
   logic        rx_sample, rx_bit_end;

   assign rx_fall    = rx_prev && !sync1;
   assign rx_sample  = (rx_cnt == (rx_div >> 1));
   assign rx_bit_end = (rx_cnt == rx_div - 16'd1);

   // Two-flop synchronizer plus one history flop for start-edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync0   <= 1'b1;
         sync1   <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         sync0   <= rx;
         sync1   <= sync0;
         rx_prev <= sync1;
      end
   end

   // RX frame sequencer; returns to IDLE at mid-stop so the next start edge is caught
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_state     <= RX_IDLE;
         rx_div       <= 16'(CLK_DIV_RST);
         rx_cnt       <= '0;
         rx_shift     <= '0;
         rx_bit       <= '0;
         rx_par_en    <= 1'b0;
         rx_par_odd   <= 1'b0;
         rx_par_ok    <= 1'b0;
         rx_push      <= 1'b0;
         rx_push_data <= '0;
         overrun      <= 1'b0;
         framing_err  <= 1'b0;
         parity_err   <= 1'b0;
      end else begin
         rx_push <= 1'b0;
         // Clears first so that a same-cycle error below overrides them
         if (errclr && data_in[ST_OVERRUN]) overrun     <= 1'b0;
         if (errclr && data_in[ST_FRAMING]) framing_err <= 1'b0;
         if (errclr && data_in[ST_PARITY])  parity_err  <= 1'b0;
         if (rx_state == RX_IDLE) begin
            if (rx_fall) begin
               rx_state   <= RX_START;
               rx_cnt     <= '0;
               rx_div     <= divisor;
               rx_par_en  <= parity_en;
               rx_par_odd <= parity_odd;
               rx_bit     <= '0;
            end
         end else begin
            rx_cnt <= rx_bit_end ? 16'd0 : rx_cnt + 16'd1;
            case (rx_state)
               RX_START: begin
                  if (rx_sample && sync1) rx_state <= RX_IDLE;
                  else if (rx_bit_end)    rx_state <= RX_DATA;
               end
               RX_DATA: begin
                  if (rx_sample) rx_shift <= {sync1, rx_shift[7:1]};
                  if (rx_bit_end) begin
                     rx_bit <= rx_bit + 3'd1;
                     if (rx_bit == 3'd7) rx_state <= rx_par_en ? RX_PARITY : RX_STOP;
                  end
               end
               RX_PARITY: begin
                  if (rx_sample)  rx_par_ok <= (sync1 == ((^rx_shift) ^ rx_par_odd));
                  if (rx_bit_end) rx_state  <= RX_STOP;
               end
               RX_STOP: begin
                  if (rx_sample) begin
                     rx_state <= RX_IDLE;
                     if (!sync1)                        framing_err <= 1'b1;
                     else if (rx_par_en && !rx_par_ok)  parity_err  <= 1'b1;
                     else if (rx_full)                  overrun     <= 1'b1;
                     else begin
                        rx_push      <= 1'b1;
                        rx_push_data <= rx_shift;
                     end
                  end
               end
               default: rx_state <= RX_IDLE;
            endcase
         end
      end
   end

   // Registered level interrupt
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) irq <= 1'b0;
      else        irq <= (irq_rx_en && !rx_empty) ||
                         (irq_txe_en && (tx_count == '0) && !tx_busy) ||
                         overrun || framing_err || parity_err;
   end

   // Combinational register read mux
   always_comb begin
      data_out = '0;
      case (reg_sel)
         OFF_STATUS: data_out = {8'd0, parity_err, framing_err, overrun, tx_busy,
                                 rx_empty, tx_full, rx_count9, tx_count9};
         OFF_CTRL:   data_out = {11'd0, irq_txe_en, irq_rx_en, two_stop, parity_odd,
                                 parity_en, divisor};
         OFF_RXDATA: data_out = {23'd0, !rx_empty, rx_fifo_data};
         default:    data_out = '0;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
//------------------------------------------------------------------------------
// Module  : tb_uart_ctrl
// Purpose : Self-checking bench for uart_ctrl (FIFO depth 4).
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
module tb_uart_ctrl;

   localparam logic [5:0] A_STATUS = 6'h00;
   localparam logic [5:0] A_CTRL   = 6'h04;
   localparam logic [5:0] A_TXDATA = 6'h08;
   localparam logic [5:0] A_RXDATA = 6'h0C;
   localparam logic [5:0] A_ERRCLR = 6'h10;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        tx;
   logic        rx;
   logic        rx_drv = 1'b1;
   logic        loopback = 1'b0;
   logic [5:0]  addr = '0;
   logic [31:0] data_in = '0;
   logic [31:0] data_out;
   logic        write_enable = 1'b0;
   logic        read_enable = 1'b0;
   logic        irq;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_q[$];
   logic        bit_q[$];

   assign rx = loopback ? tx : rx_drv;

   uart_ctrl #(.CLK_DIV_RST(16), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .tx(tx), .rx(rx), .addr(addr),
      .data_in(data_in), .data_out(data_out), .write_enable(write_enable),
      .read_enable(read_enable), .irq(irq));

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic bus_write(input logic [5:0] a, input logic [31:0] d);
      addr = a; data_in = d; write_enable = 1'b1;
      @(negedge clk);
      write_enable = 1'b0; data_in = '0;
   endtask

   task automatic bus_read(input logic [5:0] a, output logic [31:0] d);
      addr = a;
      #1;
      d = data_out;
   endtask

   task automatic pop_rx(output logic [31:0] d);
      addr = A_RXDATA;
      #1;
      d = data_out;
      read_enable = 1'b1;
      @(negedge clk);
      read_enable = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop, input int div);
      rx_drv = 1'b0;
      repeat (div) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_drv = b[i];
         repeat (div) @(negedge clk);
      end
      rx_drv = stop;
      repeat (div) @(negedge clk);
      rx_drv = 1'b1;
   endtask

   task automatic wait_tx_fall(input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (tx === 1'b0) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: tx start bit got none expected fall within 30 clocks", name);
      end
   endtask

   task automatic test_reset();
      logic [31:0] s;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
      bus_read(A_STATUS, s);
      checks++;
      if (s !== 32'h0008_0000) begin errors++; $display("FAIL reset_status: got %h expected 00080000", s); end
      bus_read(A_CTRL, s);
      checks++;
      if (s !== 32'h0000_0010) begin errors++; $display("FAIL reset_ctrl: got %h expected 00000010", s); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_ctrl();
      logic [31:0] s;
      bus_write(A_CTRL, 32'h001F_0002);
      bus_read(A_CTRL, s);
      checks++;
      if (s !== 32'h001F_0004) begin errors++; $display("FAIL ctrl_clamp: got %h expected 001f0004", s); end
      @(negedge clk);
      bus_write(A_CTRL, 32'h0000_1234);
      bus_read(A_CTRL, s);
      checks++;
      if (s !== 32'h0000_1234) begin errors++; $display("FAIL ctrl_rw: got %h expected 00001234", s); end
      @(negedge clk);
   endtask

   task automatic test_tx_wave();
      logic [31:0] s;
      logic [7:0]  b = 8'h55;
      logic        eb;
      bus_write(A_CTRL, 32'h0000_0004);
      for (int i = 0; i < 4; i++) bit_q.push_back(1'b0);
      for (int k = 0; k < 8; k++)
         for (int i = 0; i < 4; i++) bit_q.push_back(b[k]);
      for (int i = 0; i < 4; i++) bit_q.push_back(1'b1);
      bus_write(A_TXDATA, {24'd0, b});
      wait_tx_fall("tx_wave_start");
      while (bit_q.size() > 0) begin
         eb = bit_q.pop_front();
         checks++;
         if (tx !== eb) begin
            errors++;
            $display("FAIL tx_wave_bit%0d: got %b expected %b", 40 - bit_q.size() - 1, tx, eb);
         end
         @(negedge clk);
      end
      bus_read(A_STATUS, s);
      checks++;
      if (s[20] !== 1'b0 || s[8:0] !== 9'd0) begin
         errors++;
         $display("FAIL tx_wave_idle: got busy=%b count=%0d expected busy=0 count=0", s[20], s[8:0]);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [31:0] s;
      int  cnt = 0;
      bit  seen_high = 1'b0;
      bit  done = 1'b0;
      bus_write(A_TXDATA, 32'h0000_00FF);
      bus_write(A_TXDATA, 32'h0000_00FF);
      wait_tx_fall("b2b_first_start");
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         cnt++;
         if (tx === 1'b1) seen_high = 1'b1;
         else if (seen_high) break;
      end
      checks++;
      if (cnt != 40) begin errors++; $display("FAIL b2b_gap: got %0d clocks expected 40", cnt); end
      for (int i = 0; i < 100; i++) begin
         bus_read(A_STATUS, s);
         if (s[20] === 1'b0) begin done = 1'b1; break; end
         @(negedge clk);
      end
      checks++;
      if (!done) begin errors++; $display("FAIL b2b_idle: got busy=1 expected busy=0 within 100 clocks"); end
      @(negedge clk);
   endtask

   task automatic test_loopback();
      logic [31:0] s, got, exp;
      logic [7:0]  bytes [3] = '{8'h00, 8'hFF, 8'hA5};
      bit done = 1'b0;
      bus_write(A_CTRL, 32'h0003_0008);
      loopback = 1'b1;
      foreach (bytes[i]) begin
         exp_q.push_back({23'd0, 1'b1, bytes[i]});
         bus_write(A_TXDATA, {24'd0, bytes[i]});
      end
      for (int i = 0; i < 800; i++) begin
         bus_read(A_STATUS, s);
         if (s[17:9] == 9'd3 && s[20] == 1'b0) begin done = 1'b1; break; end
         @(negedge clk);
      end
      @(negedge clk);
      checks++;
      if (!done) begin errors++; $display("FAIL loop_wait: got rx_count=%0d expected 3", s[17:9]); end
      while (exp_q.size() > 0) begin
         exp = exp_q.pop_front();
         pop_rx(got);
         checks++;
         if (got !== exp) begin errors++; $display("FAIL loop_rxdata: got %h expected %h", got, exp); end
      end
      bus_read(A_STATUS, s);
      checks++;
      if (s[23:19] !== 5'b00001) begin errors++; $display("FAIL loop_flags: got %b expected 00001", s[23:19]); end
      @(negedge clk);
      loopback = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_overrun();
      logic [31:0] s, got, exp;
      logic [7:0]  bytes [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      bus_write(A_CTRL, 32'h0000_0008);
      foreach (bytes[i]) begin
         if (i < 4) exp_q.push_back({23'd0, 1'b1, bytes[i]});
         send_frame(bytes[i], 1'b1, 8);
      end
      repeat (12) @(negedge clk);
      bus_read(A_STATUS, s);
      checks++;
      if (s[17:9] !== 9'd4) begin errors++; $display("FAIL ovr_count: got %0d expected 4", s[17:9]); end
      checks++;
      if (s[21] !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b expected 1", s[21]); end
      checks++;
      if (irq !== 1'b1) begin errors++; $display("FAIL ovr_irq: got %b expected 1", irq); end
      @(negedge clk);
      while (exp_q.size() > 0) begin
         exp = exp_q.pop_front();
         pop_rx(got);
         checks++;
         if (got !== exp) begin errors++; $display("FAIL ovr_rxdata: got %h expected %h", got, exp); end
      end
      bus_write(A_ERRCLR, 32'h0020_0000);
      @(negedge clk);
      bus_read(A_STATUS, s);
      checks++;
      if (s[21] !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b expected 0", s[21]); end
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL ovr_irq_clear: got %b expected 0", irq); end
      @(negedge clk);
   endtask

   task automatic test_framing();
      logic [31:0] s;
      logic [7:0]  b = 8'hC3;
      bit seen = 1'b0;
      bus_write(A_CTRL, 32'h0000_0008);
      rx_drv = 1'b0;
      repeat (8) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_drv = b[i];
         repeat (8) @(negedge clk);
      end
      rx_drv = 1'b0;
      for (int i = 0; i < 24; i++) begin
         bus_read(A_STATUS, s);
         if (s[22] === 1'b1) begin seen = 1'b1; break; end
         @(negedge clk);
      end
      checks++;
      if (!seen) begin errors++; $display("FAIL frm_flag: got 0 expected 1 within 24 clocks"); end
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL frm_irq_same_cycle: got %b expected 0", irq); end
      @(negedge clk);
      checks++;
      if (irq !== 1'b1) begin errors++; $display("FAIL frm_irq_next_cycle: got %b expected 1", irq); end
      repeat (8) @(negedge clk);
      rx_drv = 1'b1;
      repeat (16) @(negedge clk);
      bus_read(A_STATUS, s);
      checks++;
      if (s[19] !== 1'b1 || s[17:9] !== 9'd0) begin
         errors++;
         $display("FAIL frm_discard: got rx_empty=%b rx_count=%0d expected 1 and 0", s[19], s[17:9]);
      end
      @(negedge clk);
      bus_write(A_ERRCLR, 32'h0040_0000);
      bus_read(A_STATUS, s);
      checks++;
      if (s[22] !== 1'b0) begin errors++; $display("FAIL frm_clear: got %b expected 0", s[22]); end
      @(negedge clk);
   endtask

   task automatic test_glitch();
      logic [31:0] s, got, exp;
      bus_write(A_CTRL, 32'h0000_0008);
      rx_drv = 1'b0;
      repeat (2) @(negedge clk);
      rx_drv = 1'b1;
      repeat (30) @(negedge clk);
      bus_read(A_STATUS, s);
      checks++;
      if (s !== 32'h0008_0000) begin errors++; $display("FAIL glitch_status: got %h expected 00080000", s); end
      @(negedge clk);
      exp_q.push_back(32'h0000_015A);
      send_frame(8'h5A, 1'b1, 8);
      repeat (12) @(negedge clk);
      exp = exp_q.pop_front();
      pop_rx(got);
      checks++;
      if (got !== exp) begin errors++; $display("FAIL glitch_recover: got %h expected %h", got, exp); end
   endtask

   task automatic test_reset_midframe();
      logic [31:0] s;
      int lows = 0;
      bus_write(A_CTRL, 32'h0000_0008);
      bus_write(A_TXDATA, 32'h0000_00F0);
      bus_write(A_TXDATA, 32'h0000_000F);
      wait_tx_fall("rst_mid_start");
      repeat (36) @(negedge clk);
      checks++;
      if (tx !== 1'b0) begin errors++; $display("FAIL rst_mid_bit3: got %b expected 0", tx); end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (tx !== 1'b1) begin errors++; $display("FAIL rst_mid_async: got %b expected 1", tx); end
      @(negedge clk);
      rst_n = 1'b1;
      bus_read(A_STATUS, s);
      checks++;
      if (s[8:0] !== 9'd0 || s[20] !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_status: got count=%0d busy=%b expected 0 and 0", s[8:0], s[20]);
      end
      for (int i = 0; i < 250; i++) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
      end
      checks++;
      if (lows != 0) begin errors++; $display("FAIL rst_mid_no_resume: got %0d low clocks expected 0", lows); end
   endtask

   initial begin
      test_reset();
      test_ctrl();
      test_tx_wave();
      test_back_to_back();
      test_loopback();
      test_overrun();
      test_framing();
      test_glitch();
      test_reset_midframe();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_ctrl.md
UART_CTRL -- requirements
Module: uart_ctrl

Interface
REQ-001 Parameter CLK_DIV_RST, 16, reset value of the baud divisor in clocks per bit; legal range 4..65535.
REQ-002 Parameter FIFO_DEPTH, 16, entries per TX and RX FIFO; power of 2, range 2..256.
REQ-003 Port clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 Port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 Port tx  out  1  serial output, idle high.
REQ-006 Port rx  in  1  serial input, asynchronous to clk.
REQ-007 Port addr  in  6  byte address; only addr[4:2] decoded, addr[1:0] ignored.
REQ-008 Port data_in  in  32  write data.
REQ-009 Port data_out  out  32  combinational read data for addr; 0 for unmapped offsets.
REQ-010 Port write_enable  in  1  write strobe, one access per asserted cycle.
REQ-011 Port read_enable  in  1  read strobe; required only for reads with side effects.
REQ-012 Port irq  out  1  level interrupt, registered.

Function
REQ-013 0x00 STATUS (RO): [8:0] tx_count, [17:9] rx_count, [18] tx_full, [19] rx_empty, [20] tx_busy, [21] rx_overrun, [22] framing_err, [23] parity_err; rest 0.
REQ-014 0x04 CTRL (RW): [15:0] divisor, [16] parity_en, [17] parity_odd, [18] two_stop, [19] irq_rx_en, [20] irq_tx_empty_en; a divisor write below 4 stores 4.
REQ-015 0x08 TXDATA (WO): write pushes data_in[7:0] into TX FIFO; write while tx_full is dropped with no state change; reads return 0.
REQ-016 0x0C RXDATA: read returns {23'b0, valid, byte}, valid=!rx_empty; read_enable with valid pops one entry at that edge; read_enable on empty has no effect.
REQ-017 0x10 ERRCLR (WO): writing 1 to bit 21/22/23 clears the matching sticky flag; same-cycle new error wins over clear.
REQ-018 Frame: start bit 0, 8 data bits LSB first, optional parity (even unless parity_odd), 1 or 2 stop bits of 1; each bit lasts exactly divisor clocks.
REQ-019 TX FSM IDLE->START->DATA(8)->[PARITY]->STOP(1|2)->IDLE; IDLE leaves when FIFO non-empty, popping the byte on that edge; tx falls the following cycle.
REQ-020 TX reads CTRL at frame start only; CTRL changes mid-frame apply to the next frame.
REQ-021 Back-to-back: with FIFO non-empty at STOP end, next START begins the next cycle (no idle bit).
REQ-022 RX input passes a 2-flop synchronizer before any use.
REQ-023 RX FSM IDLE->START->DATA(8)->[PARITY]->STOP->IDLE; per-frame bit counter restarts on the synchronized falling edge (independent of TX timing).
REQ-024 Each bit sampled once at divisor/2 clocks after its start; start bit sampled 1 returns to IDLE (glitch reject) with no flags.
REQ-025 Stop sampled 0 sets framing_err, byte discarded; parity mismatch sets parity_err, byte discarded; only first stop bit checked on RX.
REQ-026 Good byte with RX FIFO full sets rx_overrun, byte discarded, FIFO contents unchanged.
REQ-027 Simultaneous RX push and CPU pop both take effect; rx_count unchanged; TX same for push/pop.
REQ-028 FIFO pointers wrap modulo FIFO_DEPTH; counts range 0..FIFO_DEPTH.
REQ-029 irq = (irq_rx_en & !rx_empty) | (irq_tx_empty_en & tx_count==0 & !tx_busy) | any sticky error, registered one cycle.

Reset
REQ-030 rst_n low: tx=1, irq=0, both FSMs IDLE, FIFOs empty, sticky flags 0, CTRL = {0, CLK_DIV_RST}, synchronizer flops 1.
REQ-031 Reset mid-frame aborts immediately; tx high on assertion, no partial frame resumes after release.
REQ-032 FIFO storage arrays need no reset; pointers and counts must be reset.

Structure
REQ-033 Package uart_pkg holds register offsets, CTRL/STATUS bit positions, TX/RX state encodings.
REQ-034 One sub-module sync_fifo (parameters WIDTH, DEPTH; push, pop, full, empty, count), instantiated twice, width 8.

Verification
REQ-035 Divisor 4, no parity, push 0x55 -> tx low 4 clks, bits 1,0,1,0,1,0,1,0 each 4 clks, stop high 4 clks; tx_busy clears after.
REQ-036 Loopback tx->rx, divisor 8, parity_en, odd, push 0x00,0xFF,0xA5 -> RXDATA reads 0x100,0x1FF,0x1A5 in order, no error flags.
REQ-037 FIFO_DEPTH 4, receive 5 bytes without popping -> rx_count=4, rx_overrun=1, first 4 bytes intact; ERRCLR bit21 -> overrun 0.
REQ-038 Drive frame with stop bit 0 -> framing_err=1, rx_empty stays 1; irq=1 one cycle after flag sets.
REQ-039 rx low pulse of divisor/4 clocks -> no byte, no flags, RX back IDLE.
REQ-040 rst_n low during DATA bit 3 of a TX frame -> tx=1 asynchronously, tx_count=0 after release, tx stays high.
